// File: rtl/prince_sbox_cms_sched.sv
// Feeds the 16 nibbles of a share-split 64-bit state through one external pipelined
// masked S-box and writes each result back in place. One call performs one S-layer.
module prince_sbox_cms_sched #(
  parameter int unsigned NSHARES  = 3,
  parameter int unsigned SBOX_LAT = 2,
  parameter int unsigned RND_BITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      start_ready,
  input  logic [NSHARES*64-1:0]     state_in,
  input  logic                      rnd_valid,
  input  logic [RND_BITS-1:0]       rnd_in,
  output logic                      rnd_ready,
  output logic [NSHARES*4-1:0]      sbox_x,
  output logic [RND_BITS-1:0]       sbox_rnd,
  input  logic [NSHARES*4-1:0]      sbox_y,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NSHARES*64-1:0]     state_out
);

  localparam int unsigned SW    = 64;
  localparam int unsigned NW    = 4;
  localparam int unsigned SBITS = NSHARES * SW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fsm_e;

  fsm_e                     fsm_q, fsm_d;
  logic [SBITS-1:0]         st_q, st_d;
  logic [3:0]               idx_q, idx_d;
  logic [SBOX_LAT-1:0]      pv_q, pv_d;
  logic [SBOX_LAT-1:0][3:0] pidx_q, pidx_d;
  logic                     issue;

  assign issue     = (fsm_q == S_FEED) && rnd_valid;
  assign state_out = st_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      st_q   <= '0;
      idx_q  <= '0;
      pv_q   <= '0;
      pidx_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      idx_q  <= idx_d;
      pv_q   <= pv_d;
      pidx_q <= pidx_d;
    end
  end

  // DRAIN ends once the pipe, after this cycle's shift, holds no valid entry.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (start) fsm_d = S_FEED;
      S_FEED:  if (issue && (idx_q == 4'd15)) fsm_d = S_DRAIN;
      S_DRAIN: if (pv_d == '0) fsm_d = S_DONE;
      S_DONE:  if (out_ready) fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  // Valid/index pipe mirrors the S-box latency; its tail selects the write-back nibble.
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    pv_d   = SBOX_LAT'({pv_q, issue});
    pidx_d = (SBOX_LAT*4)'({pidx_q, idx_q});
    if ((fsm_q == S_IDLE) && start) begin
      st_d  = state_in;
      idx_d = '0;
    end else begin
      if (issue) idx_d = idx_q + 4'd1;
      if (pv_q[SBOX_LAT-1]) begin
        for (int unsigned s = 0; s < NSHARES; s++) begin
          st_d[s*SW + 32'(pidx_q[SBOX_LAT-1])*NW +: NW] = sbox_y[s*NW +: NW];
        end
      end
    end
  end

  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    rnd_ready   = 1'b0;
    sbox_x      = '0;
    sbox_rnd    = '0;
    case (fsm_q)
      S_IDLE:  start_ready = 1'b1;
      S_FEED:  busy = 1'b1;
      S_DRAIN: busy = 1'b1;
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: start_ready = 1'b0;
    endcase
    if (issue) begin
      rnd_ready = 1'b1;
      sbox_rnd  = rnd_in;
      for (int unsigned s = 0; s < NSHARES; s++) begin
        sbox_x[s*NW +: NW] = st_q[s*SW + 32'(idx_q)*NW +: NW];
      end
    end
  end

endmodule

// File: tb/tb_prince_sbox_cms_sched.sv
// Bench for prince_sbox_cms_sched: three builds (SBOX_LAT 2/1/4) with stub S-boxes,
// a nibble-order model checked every cycle, and directed end-to-end scenarios.
module tb_prince_sbox_cms_sched;

  localparam int unsigned SB = 3 * 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, rnd_valid, ref_mode, chk_en;
  logic [3:0]      rnd_in;
  logic            start_a [3];
  logic            out_ready_a [3];
  logic [SB-1:0]   state_in_a [3];
  logic            start_ready_a [3], rnd_ready_a [3], busy_a [3], out_valid_a [3];
  logic [11:0]     sbox_x_a [3];
  logic [3:0]      sbox_rnd_a [3];
  logic [SB-1:0]   state_out_a [3];

  int cmp_n = 0;
  int mis_n = 0;

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hB; 4'h1: sb = 4'hF; 4'h2: sb = 4'h3; 4'h3: sb = 4'h2;
      4'h4: sb = 4'hA; 4'h5: sb = 4'hC; 4'h6: sb = 4'h9; 4'h7: sb = 4'h1;
      4'h8: sb = 4'h6; 4'h9: sb = 4'h7; 4'hA: sb = 4'h8; 4'hB: sb = 4'h0;
      4'hC: sb = 4'hE; 4'hD: sb = 4'h5; 4'hE: sb = 4'hD; default: sb = 4'h4;
    endcase
  endfunction

  function automatic logic [63:0] slayer(input logic [63:0] v);
    for (int i = 0; i < 16; i++) slayer[i*4 +: 4] = sb(v[i*4 +: 4]);
  endfunction

  function automatic logic [63:0] recomb(input logic [SB-1:0] v);
    recomb = v[63:0] ^ v[127:64] ^ v[191:128];
  endfunction

  task automatic chk(input string nm, input logic [SB-1:0] act, input logic [SB-1:0] exp);
    cmp_n++;
    if (act !== exp) begin
      mis_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stub S-box per build: identity per share, or recombine/S-box/re-mask with rnd.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    logic [11:0] px [L];
    logic [3:0]  pr [L];
    logic [11:0] y;
    logic [3:0]  m1, m2, xr;

    always_ff @(posedge clk) begin
      px[0] <= sbox_x_a[k];
      pr[0] <= sbox_rnd_a[k];
      for (int i = 1; i < L; i++) begin
        px[i] <= px[i-1];
        pr[i] <= pr[i-1];
      end
    end

    always_comb begin
      m1 = pr[L-1];
      m2 = {pr[L-1][0], pr[L-1][3:1]} ^ 4'h9;
      xr = px[L-1][3:0] ^ px[L-1][7:4] ^ px[L-1][11:8];
      if (ref_mode) y = {m2, m1, sb(xr) ^ m1 ^ m2};
      else          y = px[L-1];
    end

    prince_sbox_cms_sched #(.NSHARES(3), .SBOX_LAT(L), .RND_BITS(4)) u_dut (
      .clk(clk), .rst(rst), .start(start_a[k]), .start_ready(start_ready_a[k]),
      .state_in(state_in_a[k]), .rnd_valid(rnd_valid), .rnd_in(rnd_in),
      .rnd_ready(rnd_ready_a[k]), .sbox_x(sbox_x_a[k]), .sbox_rnd(sbox_rnd_a[k]),
      .sbox_y(y), .busy(busy_a[k]), .out_valid(out_valid_a[k]),
      .out_ready(out_ready_a[k]), .state_out(state_out_a[k])
    );
  end

  // Issue model for build 0: after an accepted start, nibbles 0..15 are handed out in
  // order, one per cycle with rnd_valid high, and the bus is zero otherwise.
  int            issued = 0;
  bit            feeding = 1'b0;
  int            load_req = 0;
  int            load_ack = 0;
  logic [SB-1:0] sin_m;

  always @(negedge clk) begin
    logic        exp_rr;
    logic [11:0] exp_x;
    if (chk_en) begin
      exp_rr = feeding && rnd_valid;
      exp_x  = '0;
      if (exp_rr) for (int s = 0; s < 3; s++) exp_x[s*4 +: 4] = sin_m[s*64 + issued*4 +: 4];
      chk("rnd_ready", SB'(rnd_ready_a[0]), SB'(exp_rr));
      chk("sbox_x", SB'(sbox_x_a[0]), SB'(exp_x));
      chk("sbox_rnd", SB'(sbox_rnd_a[0]), exp_rr ? SB'(rnd_in) : '0);
      if (rst) feeding = 1'b0;
      else if (exp_rr) begin
        issued++;
        if (issued == 16) feeding = 1'b0;
      end
    end
    if (load_req != load_ack) begin
      load_ack = load_req;
      feeding  = 1'b1;
      issued   = 0;
      sin_m    = state_in_a[0];
    end
  end

  task automatic start_call(input int k, input logic [SB-1:0] st);
    state_in_a[k] = st;
    start_a[k]    = 1'b1;
    if (k == 0) load_req++;
    @(posedge clk); #1;
    start_a[k] = 1'b0;
  endtask

  // Counts cycles from FEED entry until out_valid, dropping rnd_valid where mask is set.
  task automatic wait_done(input int k, input logic [31:0] mask, input int exp_n,
                           input string nm, output logic [SB-1:0] res);
    int n = 0;
    rnd_valid = ~mask[0];
    rnd_in    = 4'd3;
    while (out_valid_a[k] !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
      rnd_valid = (n < 32) ? ~mask[n] : 1'b1;
      rnd_in    = 4'(n * 5 + 3);
    end
    rnd_valid = 1'b1;
    chk({nm, "_latency"}, SB'(n), SB'(exp_n));
    res = state_out_a[0];
    if (k != 0) res = state_out_a[k];
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_start_ready"}, SB'(start_ready_a[0]), SB'(1'b1));
    chk({nm, "_busy"}, SB'(busy_a[0]), '0);
    chk({nm, "_out_valid"}, SB'(out_valid_a[0]), '0);
    chk({nm, "_rnd_ready"}, SB'(rnd_ready_a[0]), '0);
    chk({nm, "_sbox_x"}, SB'(sbox_x_a[0]), '0);
    chk({nm, "_sbox_rnd"}, SB'(sbox_rnd_a[0]), '0);
  endtask

  task automatic release_done();
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SB-1:0] a, b, r, r1, r2;
    logic [63:0]   s1, s2;
    int            lat1, lat2;
    rst = 1'b1; rnd_valid = 1'b1; rnd_in = '0; ref_mode = 1'b0; chk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0; out_ready_a[k] = 1'b0; state_in_a[k] = '0;
    end
    out_ready_a[1] = 1'b1;
    out_ready_a[2] = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk_idle("reset");
    chk("reset_state_out", state_out_a[0], '0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk_idle("idle");

    // identity S-box: the state must come back unchanged after 18 cycles
    a = {64'hDEADBEEF01234567, 64'h0F1E2D3C4B5A6978, 64'h8899AABBCCDDEEFF};
    start_call(0, a);
    chk("feed_busy", SB'(busy_a[0]), SB'(1'b1));
    wait_done(0, 32'h0, 18, "ident", r);
    chk("ident_result", r, a);
    release_done();
    chk_idle("ident_back");

    // reference S-box on a share split of 0x0123456789ABCDEF
    ref_mode = 1'b1;
    s1 = 64'h5A5A1234C3C39876;
    s2 = 64'h13579BDF2468ACE0;
    b  = {s2, s1, 64'h0123456789ABCDEF ^ s1 ^ s2};
    start_call(0, b);
    wait_done(0, 32'h0, 18, "ref", r);
    chk("ref_result", SB'(recomb(r)), SB'(64'hBF32AC916780E5D4));
    release_done();

    // randomness gaps on feed cycles 3 and 9, result must match the S-layer model
    start_call(0, b);
    wait_done(0, 32'h0000_0208, 20, "gap", r);
    chk("gap_result", SB'(recomb(r)), SB'(slayer(64'h0123456789ABCDEF)));

    // backpressure in DONE with stray start pulses
    for (int i = 0; i < 5; i++) begin
      start_a[0] = i[0];
      @(posedge clk); #1;
      chk("bp_out_valid", SB'(out_valid_a[0]), SB'(1'b1));
      chk("bp_state_out", state_out_a[0], r);
      chk("bp_start_ready", SB'(start_ready_a[0]), '0);
    end
    start_a[0] = 1'b1;
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
    chk("bp_idle_start_ready", SB'(start_ready_a[0]), SB'(1'b1));
    chk("bp_idle_out_valid", SB'(out_valid_a[0]), '0);
    load_req++;
    @(posedge clk); #1;
    start_a[0] = 1'b0;
    chk("bp_restart_busy", SB'(busy_a[0]), SB'(1'b1));
    wait_done(0, 32'h0, 18, "restart", r);
    chk("restart_result", SB'(recomb(r)), SB'(64'hBF32AC916780E5D4));
    release_done();

    // reset in the middle of feeding, then a clean call
    ref_mode = 1'b0;
    start_call(0, a);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle("abort");
    chk("abort_state_out", state_out_a[0], '0);
    @(posedge clk); #1;
    chk("abort_state_out_late", state_out_a[0], '0);
    start_call(0, ~a);
    wait_done(0, 32'h0, 18, "post_abort", r);
    chk("post_abort_result", r, ~a);
    release_done();

    // other latency builds
    ref_mode = 1'b1;
    state_in_a[1] = b; state_in_a[2] = b;
    start_a[1] = 1'b1; start_a[2] = 1'b1;
    @(posedge clk); #1;
    start_a[1] = 1'b0; start_a[2] = 1'b0;
    lat1 = -1; lat2 = -1; r1 = '0; r2 = '0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid_a[1] === 1'b1 && lat1 < 0) begin lat1 = n; r1 = state_out_a[1]; end
      if (out_valid_a[2] === 1'b1 && lat2 < 0) begin lat2 = n; r2 = state_out_a[2]; end
      @(posedge clk); #1;
    end
    chk("lat1_latency", SB'(lat1), SB'(17));
    chk("lat4_latency", SB'(lat2), SB'(20));
    chk("lat1_result", SB'(recomb(r1)), SB'(64'hBF32AC916780E5D4));
    chk("lat4_result", SB'(recomb(r2)), SB'(64'hBF32AC916780E5D4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
    $finish;
  end

endmodule
